// File: rtl/iomem_pkg.sv
// Shared iomem bus definitions: write-strobe encodings, address width and
// the state encoding of the iomem DMA word-copy engine.
package iomem_pkg;

    localparam int          IOMEM_ADDR_W = 32;
    localparam logic [3:0]  WSTRB_READ   = 4'b0000;
    localparam logic [3:0]  WSTRB_WORD   = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_FIN  = 3'd3,
        ST_ERR  = 3'd4
    } dma_state_t;

endpackage

// File: rtl/iomem_dma_master.sv
// iomem DMA master: copies len_words 32-bit words from src to dst, one read
// followed by one write per word, over the iomem valid/ready bus.
// Optional watchdog: define DMA_TIMEOUT_EN to abort a request whose ready
// never arrives within TIMEOUT_CYCLES (sets sticky error).
module iomem_dma_master
    import iomem_pkg::*;
#(
    parameter int LEN_W          = 16,
    parameter int ADDR_INC       = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic                    abort,
    input  logic [IOMEM_ADDR_W-1:0] src_addr,
    input  logic [IOMEM_ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]        len_words,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [LEN_W-1:0]        words_done,
    output logic                    iomem_valid,
    output logic [3:0]              iomem_wstrb,
    output logic [IOMEM_ADDR_W-1:0] iomem_addr,
    output logic [31:0]             iomem_wdata,
    input  logic                    iomem_ready,
    input  logic [31:0]             iomem_rdata
);

    dma_state_t              state_q, state_d;
    logic                    gap_q;      // one idle-valid cycle after each handshake
    logic                    abort_q;    // abort seen while busy, honoured at word end
    logic [IOMEM_ADDR_W-1:0] src_q, dst_q;
    logic [31:0]             data_q;
    logic [LEN_W-1:0]        rem_q, words_q;
    logic                    hs, accept, timeout_hit;

    assign busy        = (state_q == ST_RD) || (state_q == ST_WR);
    assign done        = (state_q == ST_FIN) || (state_q == ST_ERR);
    // valid is decoded from registers so an async reset drops it at once
    assign iomem_valid = busy && !gap_q;
    assign hs          = iomem_valid && iomem_ready;
    assign accept      = (state_q == ST_IDLE) && start;
    assign iomem_wstrb = (iomem_valid && state_q == ST_WR) ? WSTRB_WORD : WSTRB_READ;
    assign iomem_addr  = !iomem_valid ? '0 : ((state_q == ST_RD) ? src_q : dst_q);
    assign iomem_wdata = data_q;
    assign words_done  = words_q;

`ifdef DMA_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            error_q;

    // fires on the last allowed waiting cycle, so valid is high TIMEOUT_CYCLES cycles
    assign timeout_hit = iomem_valid && !iomem_ready && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign error       = error_q;

    // wait-cycle counter: runs while a request is stalled, clears otherwise
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                         to_cnt_q <= '0;
        else if (iomem_valid && !iomem_ready) to_cnt_q <= to_cnt_q + 1'b1;
        else                                 to_cnt_q <= '0;
    end

    // sticky error: set by the watchdog, cleared by the next accepted job
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)          error_q <= 1'b0;
        else if (accept)      error_q <= 1'b0;
        else if (timeout_hit) error_q <= 1'b1;
    end
`else
    // no watchdog: a negative limit is the only way this could ever fire
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
    assign error       = 1'b0;
`endif

    // next-state: RD and WR each spend their gap cycle before moving on
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = (len_words == '0) ? ST_FIN : ST_RD;
            ST_RD: begin
                if (timeout_hit) state_d = ST_ERR;
                else if (gap_q)  state_d = ST_WR;
            end
            ST_WR: begin
                if (timeout_hit) state_d = ST_ERR;
                else if (gap_q)  state_d = (rem_q != '0 && !abort_q && !abort) ? ST_RD : ST_FIN;
            end
            ST_FIN:  state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // job latch, read-data capture and per-word progress
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gap_q   <= 1'b0;
            abort_q <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            rem_q   <= '0;
            words_q <= '0;
        end else begin
            gap_q <= hs;
            if (accept) begin
                src_q   <= {src_addr[IOMEM_ADDR_W-1:2], 2'b00};
                dst_q   <= {dst_addr[IOMEM_ADDR_W-1:2], 2'b00};
                rem_q   <= len_words;
                words_q <= '0;
                abort_q <= 1'b0;
            end else begin
                if (abort && busy) abort_q <= 1'b1;
                if (hs && state_q == ST_RD) data_q <= iomem_rdata;
                if (hs && state_q == ST_WR) begin
                    words_q <= words_q + 1'b1;
                    rem_q   <= rem_q - 1'b1;
                    src_q   <= src_q + IOMEM_ADDR_W'(ADDR_INC);
                    dst_q   <= dst_q + IOMEM_ADDR_W'(ADDR_INC);
                end
            end
        end
    end

endmodule

// File: tb/tb_iomem_dma_master.sv
// Bench for iomem_dma_master: randomized responder with a memory model,
// expected bus transactions built from the job parameters, per-cycle compare.
module tb_iomem_dma_master;

    localparam int LEN_W = 16;
    localparam int TO    = 255;

    logic              clk = 1'b0;
    logic              resetn;
    logic              start, abort;
    logic [31:0]       src_addr, dst_addr;
    logic [LEN_W-1:0]  len_words;
    logic              busy, done, error;
    logic [LEN_W-1:0]  words_done;
    logic              iomem_valid;
    logic [3:0]        iomem_wstrb;
    logic [31:0]       iomem_addr, iomem_wdata;
    logic              iomem_ready;
    logic [31:0]       iomem_rdata;

    iomem_dma_master #(.LEN_W(LEN_W), .ADDR_INC(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
        .busy(busy), .done(done), .error(error), .words_done(words_done),
        .iomem_valid(iomem_valid), .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_ready(iomem_ready), .iomem_rdata(iomem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] seen_addr[$];
    int          tests = 0, fails = 0;
    int          cyc = 0;
    int          rd_start = 0, wr_start = 0, valid_cycles = 0;
    logic [31:0] salt = 32'h0;
    int          wait_fix = 0, wait_max = 0;
    bit          never_ready = 0, spurious = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // memory contents seen by the responder for any byte address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ salt ^ 32'h5A5A0F0F;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // responder: per-request wait states, ready pulses one cycle, rdata with ready
    initial begin
        int  wleft;
        bit  in_txn;
        in_txn = 0; wleft = 0;
        iomem_ready = 1'b0; iomem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!resetn) begin
                iomem_ready = 1'b0; in_txn = 0;
            end else if (iomem_valid) begin
                if (!in_txn) begin
                    in_txn = 1;
                    if (never_ready)       wleft = 1 << 30;
                    else if (wait_fix >= 0) wleft = wait_fix;
                    else                   wleft = $urandom_range(wait_max, 0);
                end
                if (wleft == 0) begin
                    iomem_ready = 1'b1;
                    iomem_rdata = mem_word(iomem_addr);
                    in_txn = 0;
                end else begin
                    iomem_ready = 1'b0;
                    iomem_rdata = $urandom;
                    wleft--;
                end
            end else begin
                in_txn = 0;
                iomem_ready = spurious ? 1'($urandom_range(1, 0)) : 1'b0;
                iomem_rdata = $urandom;
            end
        end
    end

    // compare process: every handshake against the expected queue, plus
    // request stability while stalled and the mandatory gap after a handshake
    initial begin
        bit          held, last_hs;
        logic [31:0] p_addr, p_wdata;
        logic [3:0]  p_wstrb;
        txn_t        t;
        held = 0; last_hs = 0;
        p_addr = '0; p_wdata = '0; p_wstrb = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                held = 0; last_hs = 0;
            end else begin
                if (last_hs) chk("gap_after_hs", 32'(iomem_valid), 32'd0);
                last_hs = 0;
                if (iomem_valid) begin
                    valid_cycles++;
                    chk("busy_with_valid", 32'(busy), 32'd1);
                    if (held) begin
                        chk("stable_addr", iomem_addr, p_addr);
                        chk("stable_wstrb", 32'(iomem_wstrb), 32'(p_wstrb));
                        if (iomem_wstrb == 4'hF) chk("stable_wdata", iomem_wdata, p_wdata);
                    end else begin
                        if (iomem_wstrb == 4'h0) rd_start++;
                        else                     wr_start++;
                    end
                    if (iomem_ready) begin
                        seen_addr.push_back(iomem_addr);
                        if (exp_q.size() == 0) begin
                            chk("unexpected_txn", 32'd0, 32'd1);
                        end else begin
                            t = exp_q.pop_front();
                            chk("txn_addr", iomem_addr, t.addr);
                            chk("txn_wstrb", 32'(iomem_wstrb), 32'(t.wstrb));
                            if (t.wstrb == 4'hF) chk("txn_wdata", iomem_wdata, t.wdata);
                        end
                        last_hs = 1; held = 0;
                    end else begin
                        held = 1;
                        p_addr = iomem_addr; p_wstrb = iomem_wstrb; p_wdata = iomem_wdata;
                    end
                end else begin
                    held = 0;
                end
            end
        end
    end

    // expected bus traffic of a job that completes n words
    task automatic build_exp(input logic [31:0] s, input logic [31:0] d, input int n);
        txn_t t;
        for (int i = 0; i < n; i++) begin
            t.addr = (s & 32'hFFFF_FFFC) + 32'(4 * i); t.wstrb = 4'h0; t.wdata = '0;
            exp_q.push_back(t);
            t.wdata = mem_word(t.addr);
            t.addr  = (d & 32'hFFFF_FFFC) + 32'(4 * i); t.wstrb = 4'hF;
            exp_q.push_back(t);
        end
    endtask

    task automatic run_job(input logic [31:0] s, input logic [31:0] d, input int len,
                           input int exp_words, input int abort_rd, input bit mid_start,
                           input int exp_delta, input string tag);
        int t0, delta, rd_base, vc_base;
        bit seen, ab_done, busy_seen;
        salt = $urandom;
        seen_addr.delete();
        build_exp(s, d, exp_words);
        src_addr = s; dst_addr = d; len_words = LEN_W'(len); start = 1'b1;
        @(posedge clk); #1;
        t0 = cyc; start = 1'b0; rd_base = rd_start; vc_base = valid_cycles;
        seen = 0; ab_done = 0; busy_seen = 0; delta = 0;
        for (int k = 0; k < 4000 && !seen; k++) begin
            @(negedge clk); #1;
            abort = 1'b0; start = 1'b0;
            if (busy) busy_seen = 1;
            if (done) begin
                seen = 1; delta = cyc - t0;
            end else begin
                if (abort_rd > 0 && !ab_done && iomem_valid && iomem_wstrb == 4'h0 &&
                    rd_start - rd_base == abort_rd) begin
                    abort = 1'b1; ab_done = 1;
                end
                if (mid_start && k == 3) begin
                    start = 1'b1; src_addr = 32'h1234_5678; dst_addr = 32'h0BAD_0000;
                    len_words = LEN_W'(7);
                end
            end
        end
        if (!seen) begin
            chk({tag, "_done_timeout"}, 32'd0, 32'd1);
        end else begin
            if (exp_delta >= 0) chk({tag, "_done_cycle"}, 32'(delta), 32'(exp_delta));
            chk({tag, "_words_done"}, 32'(words_done), 32'(exp_words));
            chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            chk({tag, "_error"}, 32'(error), 32'd0);
            chk({tag, "_pending_txns"}, 32'(exp_q.size()), 32'd0);
            if (len == 0) begin
                chk({tag, "_busy_seen"}, 32'(busy_seen), 32'd0);
                chk({tag, "_valid_cycles"}, 32'(valid_cycles - vc_base), 32'd0);
            end
        end
        @(negedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; len_words = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(iomem_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_words", 32'(words_done), 32'd0);
        chk("rst_addr", iomem_addr, 32'd0);
        chk("rst_wstrb", 32'(iomem_wstrb), 32'd0);
        chk("rst_wdata", iomem_wdata, 32'd0);
        @(posedge clk); #2 resetn = 1'b1;
        @(posedge clk); #1;

        // basic copy with zero-wait responder: 4 cycles per word, done 12 edges after start
        wait_fix = 0; spurious = 0;
        run_job(32'h0300_0100, 32'h0400_0000, 3, 3, 0, 0, 12, "t1");
        if (seen_addr.size() == 6) begin
            chk("t1_pin_rd0", seen_addr[0], 32'h0300_0100);
            chk("t1_pin_wr0", seen_addr[1], 32'h0400_0000);
            chk("t1_pin_rd2", seen_addr[4], 32'h0300_0108);
            chk("t1_pin_wr2", seen_addr[5], 32'h0400_0008);
        end else chk("t1_txn_count", 32'(seen_addr.size()), 32'd6);

        // zero length: done right after start, no bus activity
        run_job(32'h0300_0000, 32'h0400_0000, 0, 0, 0, 0, 0, "t2");

        // five wait states per request
        wait_fix = 5;
        run_job(32'h0300_0203, 32'h0400_0101, 3, 3, 0, 0, -1, "t3");

        // abort during the second read of a four-word job
        wait_fix = 0;
        run_job(32'h0300_0400, 32'h0400_0400, 4, 2, 2, 0, -1, "t4");

        // source wraps past the top of the address space; start mid-job ignored
        run_job(32'hFFFF_FFFC, 32'h0000_0010, 2, 2, 0, 1, -1, "t5");
        if (seen_addr.size() == 4) chk("t5_pin_wrap", seen_addr[2], 32'h0000_0000);
        else chk("t5_txn_count", 32'(seen_addr.size()), 32'd4);

        // randomized jobs with random wait states and stray ready pulses
        wait_fix = -1; spurious = 1;
        for (int j = 0; j < 8; j++) begin
            int n;
            n = $urandom_range(5, 1);
            wait_max = $urandom_range(3, 0);
            run_job($urandom, $urandom, n, n, 0, 0, -1, "rnd");
        end
        spurious = 0; wait_fix = 0;

        // async reset while the second write is on the bus
        begin
            int wr_base;
            bit hit;
            salt = $urandom;
            build_exp(32'h0300_0800, 32'h0400_0800, 4);
            src_addr = 32'h0300_0800; dst_addr = 32'h0400_0800; len_words = LEN_W'(4);
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            wr_base = wr_start; hit = 0;
            for (int k = 0; k < 100 && !hit; k++) begin
                @(negedge clk); #1;
                if (iomem_valid && iomem_wstrb == 4'hF && wr_start - wr_base == 2) hit = 1;
            end
            chk("ar_reached_wr", 32'(hit), 32'd1);
            chk("ar_words_before", 32'(words_done), 32'd1);
            resetn = 1'b0;
            #1;
            chk("ar_valid", 32'(iomem_valid), 32'd0);
            chk("ar_busy", 32'(busy), 32'd0);
            chk("ar_done", 32'(done), 32'd0);
            chk("ar_words", 32'(words_done), 32'd0);
            chk("ar_addr", iomem_addr, 32'd0);
            chk("ar_wstrb", 32'(iomem_wstrb), 32'd0);
            chk("ar_wdata", iomem_wdata, 32'd0);
            exp_q.delete();
            @(posedge clk); @(posedge clk); #2 resetn = 1'b1;
            @(posedge clk); #1;
            run_job(32'h0300_0C00, 32'h0400_0C00, 2, 2, 0, 0, 8, "ar_recover");
        end

`ifdef DMA_TIMEOUT_EN
        // responder never answers: watchdog drops valid and flags error
        begin
            int  vcyc;
            bit  dseen;
            never_ready = 1;
            src_addr = 32'h0300_0000; dst_addr = 32'h0400_0000; len_words = LEN_W'(1);
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            vcyc = 0; dseen = 0;
            for (int k = 0; k < 600 && !dseen; k++) begin
                @(negedge clk); #1;
                if (iomem_valid) vcyc++;
                if (done) dseen = 1;
            end
            chk("to_done", 32'(dseen), 32'd1);
            chk("to_valid_cycles", 32'(vcyc), 32'(TO));
            chk("to_error", 32'(error), 32'd1);
            never_ready = 0;
            @(negedge clk); #1;
            chk("to_error_sticky", 32'(error), 32'd1);
            chk("to_valid_low", 32'(iomem_valid), 32'd0);
            run_job(32'h0300_0010, 32'h0400_0010, 1, 1, 0, 0, 4, "to_clear");
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
